ps2_key_tracker: RTL and testbench

- Downstream consumer of the PS2 receiver's 10-bit code word {expand, break, scancode[7:0]} and its ready flag.
- Decodes make/break events for the 8 game keys (up/down for each of the 4 boards) into held-key state.
- Generates per-board step pulses with auto-repeat for the game logic.
- Handles a ready flag that stays high once set: a new event is detected by change of the code word, not only by ready edges.

---
 rtl/ps2_key_tracker_pkg.sv | 56 +++++
 rtl/ps2_key_tracker_if.sv | 8 +
 rtl/ps2_key_tracker_key_repeat_timer.sv | 57 +++++
 rtl/ps2_key_tracker.sv | 144 ++++++++++++++
 tb/tb_ps2_key_tracker.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_tracker_pkg.sv
// rtl/ps2_key_tracker_pkg.sv - shared key indices, scancodes, FSM states and key-map lookup
package ps2_key_tracker_pkg;

    localparam int NUM_KEYS   = 8;
    localparam int NUM_BOARDS = 4;

    localparam logic [2:0] KEY_B0_UP   = 3'd0;
    localparam logic [2:0] KEY_B0_DOWN = 3'd1;
    localparam logic [2:0] KEY_B1_UP   = 3'd2;
    localparam logic [2:0] KEY_B1_DOWN = 3'd3;
    localparam logic [2:0] KEY_B2_UP   = 3'd4;
    localparam logic [2:0] KEY_B2_DOWN = 3'd5;
    localparam logic [2:0] KEY_B3_UP   = 3'd6;
    localparam logic [2:0] KEY_B3_DOWN = 3'd7;

    localparam logic [7:0] SC_W          = 8'h1D;
    localparam logic [7:0] SC_S          = 8'h1B;
    localparam logic [7:0] SC_I          = 8'h43;
    localparam logic [7:0] SC_K          = 8'h42;
    localparam logic [7:0] SC_KP8        = 8'h75;
    localparam logic [7:0] SC_KP2        = 8'h72;
    localparam logic [7:0] SC_ARROW_UP   = 8'h75;
    localparam logic [7:0] SC_ARROW_DOWN = 8'h72;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        LOOKUP  = 2'd2,
        APPLY   = 2'd3
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } key_lookup_t;

    // Arrow keys and keypad 8/2 share scancodes; only the expand prefix separates them.
    function automatic key_lookup_t key_lookup(input logic expand, input logic [7:0] sc);
        key_lookup_t r;
        r.hit = 1'b1;
        r.idx = KEY_B0_UP;
        case ({expand, sc})
            {1'b0, SC_W}:          r.idx = KEY_B0_UP;
            {1'b0, SC_S}:          r.idx = KEY_B0_DOWN;
            {1'b1, SC_ARROW_UP}:   r.idx = KEY_B1_UP;
            {1'b1, SC_ARROW_DOWN}: r.idx = KEY_B1_DOWN;
            {1'b0, SC_I}:          r.idx = KEY_B2_UP;
            {1'b0, SC_K}:          r.idx = KEY_B2_DOWN;
            {1'b0, SC_KP8}:        r.idx = KEY_B3_UP;
            {1'b0, SC_KP2}:        r.idx = KEY_B3_DOWN;
            default:               r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// rtl/ps2_key_tracker_if.sv - code word and ready flag from the PS2 receiver
interface ps2_key_tracker_if;
    logic [9:0] code_in;
    logic       code_ready;

    modport master (output code_in, output code_ready);
    modport slave  (input  code_in, input  code_ready);
endinterface

// File: rtl/ps2_key_tracker_key_repeat_timer.sv
// rtl/ps2_key_tracker_key_repeat_timer.sv - one board's up/down step generator with auto-repeat
module key_repeat_timer #(
    parameter logic [23:0] REPEAT_DELAY  = 24'd5_000_000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic held_up,
    input  logic held_down,
    input  logic press_up,
    input  logic press_down,
    output logic step_up,
    output logic step_down
);
    localparam logic [24:0] FIRST_REPEAT = {1'b0, REPEAT_DELAY};
    localparam logic [24:0] NEXT_REPEAT  = FIRST_REPEAT + {1'b0, REPEAT_PERIOD};

    logic [1:0]        held;
    logic [1:0]        press;
    logic [1:0]        step;
    logic [1:0][24:0]  cnt_q;
    logic [1:0][24:0]  cnt_d;
    logic              conflict;

    assign held      = {held_down, held_up};
    assign press     = {press_down, press_up};
    assign conflict  = held_up & held_down;
    assign step_up   = step[0];
    assign step_down = step[1];

    // Counter value equals cycles since the first step; after each repeat it folds back
    // to FIRST_REPEAT so the next repeat is REPEAT_PERIOD cycles later.
    always_comb begin
        cnt_d = cnt_q;
        step  = '0;
        for (int i = 0; i < 2; i++) begin
            if (!held[i] || conflict) begin
                cnt_d[i] = '0;
            end else if (press[i]) begin
                cnt_d[i] = 25'd1;
                step[i]  = 1'b1;
            end else begin
                step[i]  = (cnt_q[i] == FIRST_REPEAT) || (cnt_q[i] == NEXT_REPEAT);
                cnt_d[i] = (cnt_q[i] == NEXT_REPEAT) ? FIRST_REPEAT + 25'd1 : cnt_q[i] + 25'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS2 make/break decoder to held keys and step pulses
// Optional KEY_TIMEOUT_EN: idle timeout force-releases held keys.
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter logic [23:0] REPEAT_DELAY  = 24'd5_000_000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd1_000_000
`ifdef KEY_TIMEOUT_EN
    ,
    parameter logic [27:0] TIMEOUT       = 28'd200_000_000
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    ps2_key_tracker_if.slave        code_if,
    output logic [NUM_KEYS-1:0]     key_state,
    output logic [NUM_KEYS-1:0]     key_press,
    output logic [NUM_KEYS-1:0]     key_release,
    output logic [NUM_BOARDS-1:0]   step_up,
    output logic [NUM_BOARDS-1:0]   step_down,
    output logic                    unknown_code
);
    state_t               state_q, state_d;
    logic                 ready_prev_q, ready_prev_d;
    logic [9:0]           last_code_q, last_code_d;
    logic [9:0]           code_q, code_d;
    logic [NUM_KEYS-1:0]  key_state_q, key_state_d;
    logic [NUM_KEYS-1:0]  key_press_q, key_press_d;
    logic [NUM_KEYS-1:0]  key_release_q, key_release_d;
    logic                 unknown_q, unknown_d;
    logic                 evt;
    key_lookup_t          lk;
`ifdef KEY_TIMEOUT_EN
    logic [27:0]          idle_q, idle_d;
`endif

    // Ready may stay high, so a changed code word also counts as a fresh event.
    assign evt = code_if.code_ready && (!ready_prev_q || (code_if.code_in != last_code_q));
    assign lk  = key_lookup(code_q[9], code_q[7:0]);

    always_comb begin
        state_d       = state_q;
        ready_prev_d  = code_if.code_ready;
        last_code_d   = last_code_q;
        code_d        = code_q;
        key_state_d   = key_state_q;
        key_press_d   = '0;
        key_release_d = '0;
        unknown_d     = 1'b0;
        if (evt) begin
            last_code_d = code_if.code_in;
        end
        // Outputs are registered on the LOOKUP->APPLY edge so they appear while in APPLY.
        case (state_q)
            IDLE: begin
                if (evt) state_d = CAPTURE;
            end
            CAPTURE: begin
                code_d  = last_code_q;
                state_d = LOOKUP;
            end
            LOOKUP: begin
                if (!lk.hit) begin
                    unknown_d = 1'b1;
                end else if (!code_q[8]) begin
                    key_state_d[lk.idx] = 1'b1;
                    key_press_d[lk.idx] = !key_state_q[lk.idx];
                end else begin
                    key_state_d[lk.idx]   = 1'b0;
                    key_release_d[lk.idx] = key_state_q[lk.idx];
                end
                state_d = APPLY;
            end
            APPLY: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef KEY_TIMEOUT_EN
        idle_d = idle_q + 28'd1;
        if (evt) begin
            idle_d = '0;
        end else if (idle_q == TIMEOUT) begin
            idle_d        = '0;
            key_release_d = key_release_d | key_state_q;
            key_state_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ready_prev_q  <= 1'b0;
            last_code_q   <= '0;
            code_q        <= '0;
            key_state_q   <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
            unknown_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ready_prev_q  <= ready_prev_d;
            last_code_q   <= last_code_d;
            code_q        <= code_d;
            key_state_q   <= key_state_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            unknown_q     <= unknown_d;
        end
    end

`ifdef KEY_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    for (genvar b = 0; b < NUM_BOARDS; b++) begin : g_board
        key_repeat_timer #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_timer (
            .clk       (clk),
            .rst       (rst),
            .held_up   (key_state_q[2*b]),
            .held_down (key_state_q[2*b+1]),
            .press_up  (key_press_q[2*b]),
            .press_down(key_press_q[2*b+1]),
            .step_up   (step_up[b]),
            .step_down (step_down[b])
        );
    end

    assign key_state    = key_state_q;
    assign key_press    = key_press_q;
    assign key_release  = key_release_q;
    assign unknown_code = unknown_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - self-checking bench for ps2_key_tracker (KEY_TIMEOUT_EN optional)
module tb_ps2_key_tracker;
    localparam int D = 20;
    localparam int R = 5;
`ifdef KEY_TIMEOUT_EN
    localparam int TO = 50;
`endif
    localparam logic [8:0] KEYMAP [8] = '{9'h01D, 9'h01B, 9'h175, 9'h172,
                                          9'h043, 9'h042, 9'h075, 9'h072};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_miss = 0;

    ps2_key_tracker_if bus();
    logic [7:0] key_state, key_press, key_release;
    logic [3:0] step_up, step_down;
    logic       unknown_code;

    ps2_key_tracker #(
        .REPEAT_DELAY (24'(D)),
        .REPEAT_PERIOD(24'(R))
`ifdef KEY_TIMEOUT_EN
        ,
        .TIMEOUT      (28'(TO))
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .code_if     (bus),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .step_up     (step_up),
        .step_down   (step_down),
        .unknown_code(unknown_code)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    // Reference model: event list with fixed 3-cycle latency, per-key hold anchors.
    int         cyc, m_free_at, m_idle;
    bit         m_prev_ready, m_ev;
    logic [9:0] m_last;
    int         pend_at [$];
    logic [9:0] pend_code [$];
    logic [7:0] m_held, m_old;
    int         anchor [8];
    bit         astep [8];
    logic [7:0] exp_state, exp_press, exp_release;
    logic [3:0] exp_up, exp_down;
    logic       exp_unk;

    wire [32:0] obs     = {key_state, key_press, key_release, step_up, step_down, unknown_code};
    wire [32:0] exp_vec = {exp_state, exp_press, exp_release, exp_up, exp_down, exp_unk};

    function automatic bit repeat_due(input int since, input bit at_start);
        return (since == 0 && at_start) || (since >= D && (since - D) % R == 0);
    endfunction

    task automatic model_clear();
        cyc = 0; m_free_at = 0; m_idle = 0;
        m_prev_ready = 1'b0; m_last = '0; m_held = '0;
        pend_at.delete(); pend_code.delete();
        exp_state = '0; exp_press = '0; exp_release = '0;
        exp_up = '0; exp_down = '0; exp_unk = 1'b0;
        for (int k = 0; k < 8; k++) begin anchor[k] = 0; astep[k] = 1'b0; end
    endtask

    task automatic model_step();
        int t, hit;
        logic [9:0] c;
        t = cyc;
        m_ev = bus.code_ready && (!m_prev_ready || bus.code_in != m_last);
        if (m_ev) m_last = bus.code_in;
        m_prev_ready = bus.code_ready;
        if (m_ev && t >= m_free_at) begin
            pend_at.push_back(t + 3);
            pend_code.push_back(bus.code_in);
            m_free_at = t + 4;
        end
        exp_press = '0; exp_release = '0; exp_unk = 1'b0;
        m_old = m_held;
        if (pend_at.size() > 0 && pend_at[0] == t + 1) begin
            c = pend_code.pop_front();
            void'(pend_at.pop_front());
            hit = -1;
            for (int k = 0; k < 8; k++) if (KEYMAP[k] == {c[9], c[7:0]}) hit = k;
            if (hit < 0) begin
                exp_unk = 1'b1;
            end else if (!c[8]) begin
                if (!m_held[hit]) begin
                    m_held[hit] = 1'b1; exp_press[hit] = 1'b1;
                    anchor[hit] = t + 1; astep[hit] = 1'b1;
                end
            end else if (m_held[hit]) begin
                m_held[hit] = 1'b0; exp_release[hit] = 1'b1;
            end
        end
`ifdef KEY_TIMEOUT_EN
        if (m_ev) m_idle = 0;
        else if (m_idle == TO) begin exp_release |= m_held; m_held = '0; m_idle = 0; end
        else m_idle++;
`endif
        for (int k = 0; k < 8; k++)
            if (m_held[k] && m_old[k^1] && !m_held[k^1]) begin anchor[k] = t + 1; astep[k] = 1'b0; end
        for (int b = 0; b < 4; b++) begin
            exp_up[b]   = m_held[2*b] && !m_held[2*b+1] && repeat_due(t + 1 - anchor[2*b], astep[2*b]);
            exp_down[b] = m_held[2*b+1] && !m_held[2*b] && repeat_due(t + 1 - anchor[2*b+1], astep[2*b+1]);
        end
        exp_state = m_held;
        cyc = t + 1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_clear();
        else model_step();
    end

    task automatic drive(input logic [9:0] c, input logic r);
        bus.code_in    = c;
        bus.code_ready = r;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); n_vec++;
            if (obs !== 33'd0) begin n_miss++; $display("FAIL reset: got %h expected %h", obs, 33'd0); end
        end
        rst = 1'b0;
    endtask

    task automatic test_single_press();
        drive(10'h01D, 1'b1);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk); n_vec++;
            if (obs !== exp_vec) begin n_miss++; $display("FAIL single_press model c%0d: got %h expected %h", i, obs, exp_vec); end
            if (i == 3) begin
                n_vec++;
                if ({key_state, key_press, step_up} !== {8'h01, 8'h01, 4'h1}) begin
                    n_miss++; $display("FAIL single_press first step: got %h expected %h", {key_state, key_press, step_up}, {8'h01, 8'h01, 4'h1});
                end
            end else if (i > 3) begin
                n_vec++;
                if (step_up !== 4'h0) begin n_miss++; $display("FAIL single_press early repeat c%0d: got %h expected 0", i, step_up); end
            end
        end
    endtask

    task automatic test_repeat();
        int k;
        for (int j = 1; j <= 22; j++) begin
            @(negedge clk); k = 11 + j; n_vec += 2;
            if (obs !== exp_vec) begin n_miss++; $display("FAIL repeat model k%0d: got %h expected %h", k, obs, exp_vec); end
            if (step_up[0] !== (k == 20 || k == 25 || k == 30)) begin
                n_miss++; $display("FAIL repeat step_up0 k%0d: got %b expected %b", k, step_up[0], (k == 20 || k == 25 || k == 30));
            end
        end
        drive(10'h11D, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk); n_vec++;
            if (obs !== exp_vec) begin n_miss++; $display("FAIL release model c%0d: got %h expected %h", i, obs, exp_vec); end
            if (i == 3) begin
                n_vec++;
                if ({key_state, key_release} !== {8'h00, 8'h01}) begin
                    n_miss++; $display("FAIL release pulse: got %h expected %h", {key_state, key_release}, {8'h00, 8'h01});
                end
            end
        end
    endtask

    task automatic test_expand();
        logic [9:0] codes [4] = '{10'h275, 10'h075, 10'h375, 10'h175};
        logic [7:0] want_state [2] = '{8'h04, 8'h44};
        logic [3:0] want_step [2] = '{4'b0010, 4'b1000};
        for (int s = 0; s < 4; s++) begin
            drive(codes[s], 1'b1);
            for (int i = 1; i <= 8; i++) begin
                @(negedge clk); n_vec++;
                if (obs !== exp_vec) begin n_miss++; $display("FAIL expand model s%0d c%0d: got %h expected %h", s, i, obs, exp_vec); end
                if (i == 3 && s < 2) begin
                    n_vec++;
                    if ({key_state, step_up} !== {want_state[s], want_step[s]}) begin
                        n_miss++; $display("FAIL expand map s%0d: got %h expected %h", s, {key_state, step_up}, {want_state[s], want_step[s]});
                    end
                end
            end
        end
    endtask

    task automatic test_conflict();
        drive(10'h01D, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk); n_vec++;
            if (obs !== exp_vec) begin n_miss++; $display("FAIL conflict press_w c%0d: got %h expected %h", i, obs, exp_vec); end
        end
        drive(10'h01B, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk); n_vec++;
            if (obs !== exp_vec) begin n_miss++; $display("FAIL conflict press_s c%0d: got %h expected %h", i, obs, exp_vec); end
            if (i >= 3) begin
                n_vec++;
                if ({key_state, step_up[0], step_down[0]} !== {8'h03, 2'b00}) begin
                    n_miss++; $display("FAIL conflict suppress c%0d: got %h expected %h", i, {key_state, step_up[0], step_down[0]}, {8'h03, 2'b00});
                end
            end
        end
        drive(10'h11D, 1'b1);
        for (int i = 1; i <= D + 6; i++) begin
            @(negedge clk); n_vec++;
            if (obs !== exp_vec) begin n_miss++; $display("FAIL conflict release_w c%0d: got %h expected %h", i, obs, exp_vec); end
            if (i >= 3 && i <= D + 3) begin
                n_vec++;
                if (step_down[0] !== (i == D + 3)) begin
                    n_miss++; $display("FAIL conflict restart c%0d: got %b expected %b", i, step_down[0], (i == D + 3));
                end
            end
        end
        drive(10'h11B, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk); n_vec++;
            if (obs !== exp_vec) begin n_miss++; $display("FAIL conflict release_s c%0d: got %h expected %h", i, obs, exp_vec); end
        end
    endtask

    task automatic test_unknown();
        drive(10'h01C, 1'b1);
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk); n_vec += 2;
            if (obs !== exp_vec) begin n_miss++; $display("FAIL unknown model c%0d: got %h expected %h", i, obs, exp_vec); end
            if ({unknown_code, key_state} !== {(i == 3), 8'h00}) begin
                n_miss++; $display("FAIL unknown pulse c%0d: got %h expected %h", i, {unknown_code, key_state}, {(i == 3), 8'h00});
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(10'h000, 1'b0);
        repeat (2) begin
            @(negedge clk); n_vec++;
            if (obs !== exp_vec) begin n_miss++; $display("FAIL reset_mid idle: got %h expected %h", obs, exp_vec); end
        end
        drive(10'h043, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); n_vec++;
            if (obs !== exp_vec) begin n_miss++; $display("FAIL reset_mid pre c%0d: got %h expected %h", i, obs, exp_vec); end
        end
        rst = 1'b1;
        @(negedge clk); n_vec++;
        if (obs !== 33'd0) begin n_miss++; $display("FAIL reset_mid clear: got %h expected %h", obs, 33'd0); end
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); n_vec++;
            if (obs !== exp_vec) begin n_miss++; $display("FAIL reset_mid post c%0d: got %h expected %h", i, obs, exp_vec); end
            if (i == 3) begin
                n_vec++;
                if ({key_state, key_press, step_up} !== {8'h10, 8'h10, 4'b0100}) begin
                    n_miss++; $display("FAIL reset_mid replay: got %h expected %h", {key_state, key_press, step_up}, {8'h10, 8'h10, 4'b0100});
                end
            end
        end
        drive(10'h143, 1'b1);
        repeat (6) begin
            @(negedge clk); n_vec++;
            if (obs !== exp_vec) begin n_miss++; $display("FAIL reset_mid release: got %h expected %h", obs, exp_vec); end
        end
    endtask

`ifdef KEY_TIMEOUT_EN
    task automatic test_timeout();
        drive(10'h01D, 1'b1);
        for (int i = 1; i <= TO + 8; i++) begin
            @(negedge clk); n_vec++;
            if (obs !== exp_vec) begin n_miss++; $display("FAIL timeout model c%0d: got %h expected %h", i, obs, exp_vec); end
            if (i == TO + 2) begin
                n_vec++;
                if ({key_state, key_release} !== {8'h00, 8'h01}) begin
                    n_miss++; $display("FAIL timeout clear: got %h expected %h", {key_state, key_release}, {8'h00, 8'h01});
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [9:0] code;
        logic [8:0] m;
        int sel, gap;
        for (int e = 0; e < 40; e++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8) begin
                m = KEYMAP[sel];
                code = {m[8], ($urandom_range(0, 2) == 0), m[7:0]};
            end else begin
                code = 10'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.code_ready = 1'b0;
                @(negedge clk); n_vec++;
                if (obs !== exp_vec) begin n_miss++; $display("FAIL random gap e%0d: got %h expected %h", e, obs, exp_vec); end
            end
            drive(code, 1'b1);
            gap = $urandom_range(5, 30);
            for (int i = 0; i < gap; i++) begin
                @(negedge clk); n_vec++;
                if (obs !== exp_vec) begin n_miss++; $display("FAIL random e%0d c%0d code %h: got %h expected %h", e, i, code, obs, exp_vec); end
            end
        end
    endtask

    initial begin
        drive(10'h000, 1'b0);
        test_reset();
        test_single_press();
        test_repeat();
        test_expand();
        test_conflict();
        test_unknown();
        test_reset_mid();
`ifdef KEY_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
